// File: rtl/lemmings_pkg.sv
// Shared definitions for the Lemmings walker controllers: the state
// encoding and small helpers on it.
package lemmings_pkg;

    typedef logic [2:0] state_t;

    localparam state_t WALK_L = 3'd0;
    localparam state_t WALK_R = 3'd1;
    localparam state_t FALL_L = 3'd2;
    localparam state_t FALL_R = 3'd3;
    localparam state_t DIG_L  = 3'd4;
    localparam state_t DIG_R  = 3'd5;
    localparam state_t SPLAT  = 3'd6;

    // True for both falling states, whichever direction is remembered.
    function automatic logic is_fall(input state_t s);
        return (s == FALL_L) || (s == FALL_R);
    endfunction

endpackage

// File: rtl/lemmings_fall_counter.sv
// Saturating fall-duration counter. It holds the number of cycles the
// lemming has been falling, counting the current one, and flags when that
// exceeds the survivable limit. It never wraps, so arbitrarily long falls
// keep the flag raised.
module lemmings_fall_counter #(
    parameter int SPLAT_CYCLES = 20,
    parameter int CNT_W        = $clog2(SPLAT_CYCLES + 2)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,   // entering a fall: this is the first falling cycle
    input  logic inc,    // still falling on the next cycle
    output logic over    // fall has lasted longer than SPLAT_CYCLES
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(SPLAT_CYCLES);
    localparam logic [CNT_W-1:0] SAT_MAX = CNT_W'(SPLAT_CYCLES + 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Load on fall entry, count while falling (saturating), clear otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= ONE;
        end else if (inc) begin
            if (cnt < SAT_MAX) begin
                cnt <= cnt + ONE;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign over = (cnt > LIMIT);

endmodule

// File: rtl/lemmings_dig_splat.sv
// Lemmings walker with digging, fall-duration tracking and a terminal
// SPLAT state. All outputs are decoded from the state register only.
// state_dbg mirrors the state register so checkers can observe the FSM.
module lemmings_dig_splat
    import lemmings_pkg::*;
#(
    parameter int SPLAT_CYCLES = 20,
    parameter bit DIG_EN       = 1'b1,
    parameter int CNT_W        = $clog2(SPLAT_CYCLES + 2)
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   bump_left,
    input  logic   bump_right,
    input  logic   ground,
    input  logic   dig,
    output logic   walk_left,
    output logic   walk_right,
    output logic   aaah,
    output logic   digging,
    output logic   splat,
    output state_t state_dbg
);

    state_t state;
    state_t state_n;
    logic   cnt_load;
    logic   cnt_inc;
    logic   fall_over;

    lemmings_fall_counter #(
        .SPLAT_CYCLES (SPLAT_CYCLES),
        .CNT_W        (CNT_W)
    ) u_fall_counter (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .inc  (cnt_inc),
        .over (fall_over)
    );

    // State register; reset lands the lemming walking left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WALK_L;
        end else begin
            state <= state_n;
        end
    end

    // Next state: falling beats digging, digging beats bumps; falls keep
    // the direction they started with.
    always_comb begin
        state_n = state;
        case (state)
            WALK_L: begin
                if (!ground)               state_n = FALL_L;
                else if (dig && DIG_EN)    state_n = DIG_L;
                else if (bump_left)        state_n = WALK_R;
            end
            WALK_R: begin
                if (!ground)               state_n = FALL_R;
                else if (dig && DIG_EN)    state_n = DIG_R;
                else if (bump_right)       state_n = WALK_L;
            end
            DIG_L: begin
                if (!ground)               state_n = FALL_L;
            end
            DIG_R: begin
                if (!ground)               state_n = FALL_R;
            end
            FALL_L: begin
                if (ground)                state_n = fall_over ? SPLAT : WALK_L;
            end
            FALL_R: begin
                if (ground)                state_n = fall_over ? SPLAT : WALK_R;
            end
            SPLAT: begin
                state_n = SPLAT;
            end
            default: begin
                state_n = WALK_L;
            end
        endcase
    end

    // Counter control: load on entry into a fall, count while it continues.
    always_comb begin
        cnt_load = !is_fall(state) && is_fall(state_n);
        cnt_inc  = is_fall(state) && !ground;
    end

    assign walk_left  = (state == WALK_L);
    assign walk_right = (state == WALK_R);
    assign aaah       = is_fall(state);
    assign digging    = (state == DIG_L) || (state == DIG_R);
    assign splat      = (state == SPLAT);
    assign state_dbg  = state;

endmodule

// File: tb/tb_lemmings_dig_splat.sv
// Bench for lemmings_dig_splat: two instances (digging enabled and
// disabled) share the same stimulus and are compared every cycle with a
// behavioural model that tracks mode, direction and total fall time.
module tb_lemmings_dig_splat;

    localparam int S = 20;

    // model modes
    localparam int M_WALK  = 0;
    localparam int M_DIG   = 1;
    localparam int M_FALL  = 2;
    localparam int M_SPLAT = 3;

    logic clk;
    logic rst;
    logic bump_left;
    logic bump_right;
    logic ground;
    logic dig;

    logic       wl0, wr0, ah0, dg0, sp0;
    logic       wl1, wr1, ah1, dg1, sp1;
    logic [2:0] st0, st1;
    logic [4:0] out0, out1;

    assign out0 = {wl0, wr0, ah0, dg0, sp0};
    assign out1 = {wl1, wr1, ah1, dg1, sp1};

    lemmings_dig_splat #(.SPLAT_CYCLES(S), .DIG_EN(1'b1)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .ground     (ground),
        .dig        (dig),
        .walk_left  (wl0),
        .walk_right (wr0),
        .aaah       (ah0),
        .digging    (dg0),
        .splat      (sp0),
        .state_dbg  (st0)
    );

    lemmings_dig_splat #(.SPLAT_CYCLES(S), .DIG_EN(1'b0)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .ground     (ground),
        .dig        (dig),
        .walk_left  (wl1),
        .walk_right (wr1),
        .aaah       (ah1),
        .digging    (dg1),
        .splat      (sp1),
        .state_dbg  (st1)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int m_mode [2];
    int m_dir  [2];   // 0 = left, 1 = right
    int m_ft   [2];   // cycles spent falling so far, unbounded
    bit m_den  [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_WALK;
            m_dir[i]  = 0;
            m_ft[i]   = 0;
        end
    endfunction

    function automatic void model_step(input bit g, input bit bl, input bit br, input bit d);
        for (int i = 0; i < 2; i++) begin
            case (m_mode[i])
                M_WALK: begin
                    if (!g) begin
                        m_mode[i] = M_FALL;
                        m_ft[i]   = 1;
                    end else if (d && m_den[i]) begin
                        m_mode[i] = M_DIG;
                    end else if (m_dir[i] == 0 && bl) begin
                        m_dir[i] = 1;
                    end else if (m_dir[i] == 1 && br) begin
                        m_dir[i] = 0;
                    end
                end
                M_DIG: begin
                    if (!g) begin
                        m_mode[i] = M_FALL;
                        m_ft[i]   = 1;
                    end
                end
                M_FALL: begin
                    if (!g) m_ft[i] = m_ft[i] + 1;
                    else if (m_ft[i] > S) m_mode[i] = M_SPLAT;
                    else m_mode[i] = M_WALK;
                end
                default: ;
            endcase
        end
    endfunction

    function automatic logic [4:0] model_out(input int i);
        case (m_mode[i])
            M_WALK:  return (m_dir[i] == 0) ? 5'b10000 : 5'b01000;
            M_FALL:  return 5'b00100;
            M_DIG:   return 5'b00010;
            default: return 5'b00001;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b expected=%b (wl,wr,aaah,dig,splat) t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "/en"},  out0, model_out(0));
        check({tag, "/dis"}, out1, model_out(1));
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a negedge: drive, let the edge happen, then compare.
    task automatic cycle(input bit g, input bit bl, input bit br, input bit d, input string tag);
        ground     = g;
        bump_left  = bl;
        bump_right = br;
        dig        = d;
        @(posedge clk);
        model_step(g, bl, br, d);
        @(negedge clk);
        check_both(tag);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must react
    // before any edge arrives.
    task automatic async_reset(input string tag);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_both(tag);
        check({tag, "/const"}, out0, 5'b10000);
        #1 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_den[0] = 1'b1;
        m_den[1] = 1'b0;
        model_reset();
        rst        = 1'b1;
        ground     = 1'b1;
        bump_left  = 1'b0;
        bump_right = 1'b0;
        dig        = 1'b0;
        @(negedge clk);
        check("reset/en",  out0, 5'b10000);
        check("reset/dis", out1, 5'b10000);
        rst = 1'b0;

        // bumps and asynchronous reset
        cycle(1, 0, 0, 0, "idle");
        cycle(1, 1, 0, 0, "bump_l");
        check("bump_l_const", out0, 5'b01000);
        cycle(1, 0, 1, 0, "bump_r");
        check("bump_r_const", out0, 5'b10000);
        cycle(1, 1, 1, 0, "bump_both");
        check("bump_both_const", out0, 5'b01000);
        async_reset("async_rst");

        // dig in WALK_R, then fall and land
        cycle(1, 1, 0, 0, "to_right");
        cycle(1, 0, 0, 1, "dig");
        check("dig_const", out0, 5'b00010);
        cycle(1, 0, 1, 0, "dig_bump");
        check("dig_bump_const", out0, 5'b00010);
        cycle(0, 0, 0, 0, "dig_fall");
        check("dig_fall_const", out0, 5'b00100);
        cycle(1, 0, 0, 1, "dig_land");
        check("dig_land_const", out0, 5'b01000);

        // fall has priority over dig and bump; direction kept
        cycle(1, 0, 1, 0, "to_left");
        cycle(0, 1, 0, 1, "fall_prio");
        check("fall_prio_const", out0, 5'b00100);
        cycle(1, 0, 0, 1, "fall_prio_land");
        check("fall_prio_land_const", out0, 5'b10000);

        // survivable boundary: exactly S falling cycles
        repeat (S) cycle(0, 0, 0, 0, "fall_s");
        cycle(1, 0, 0, 0, "land_s");
        check("land_s_const", out0, 5'b10000);

        // one cycle too many
        repeat (S + 1) cycle(0, 0, 0, 0, "fall_s1");
        cycle(1, 0, 0, 0, "land_s1");
        check("land_s1_const", out0, 5'b00001);
        async_reset("rst_from_splat");

        // saturation: very long fall
        repeat (300) cycle(0, 0, 0, 0, "fall_long");
        cycle(1, 0, 0, 0, "land_long");
        check("land_long_const", out0, 5'b00001);

        // SPLAT absorbs everything
        for (int i = 0; i < 10; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "splat_hold");
        end
        check("splat_hold_const", out0, 5'b00001);
        async_reset("rst_after_splat");

        // DIG_EN=0 instance ignores dig
        cycle(1, 0, 0, 1, "dig_disabled");
        check("dig_disabled_const", out1, 5'b10000);

        // mid-fall reset
        async_reset("pre_mid");
        cycle(0, 0, 0, 0, "mid_fall");
        cycle(0, 0, 0, 0, "mid_fall");
        async_reset("rst_mid_fall");

        // randomized traffic
        for (int it = 0; it < 600; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                int len;
                len = $urandom_range(S - 2, S + 3);
                repeat (len) cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 1)), "rnd_longfall");
                cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), "rnd_land");
            end else if (r == 1 || (m_mode[0] == M_SPLAT && r < 6)) begin
                async_reset("rnd_rst");
            end else begin
                cycle(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
